score_combo_ctrl: RTL and testbench

//  Multi-lane scoring engine with combo tracking and a combo-driven score multiplier.

---
 rtl/score_combo_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_score_combo_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/score_combo_ctrl.sv
// Multi-lane judgement scoring engine: per-lane edge detect into one-deep pending slots,
// round-robin retirement of one judgement per clock into score, combo and grade statistics.
module score_combo_ctrl #(
    parameter int NUM_LANES   = 4,
    parameter int SCORE_W     = 16,
    parameter int CNT_W       = 10,
    parameter int PTS_PERFECT = 2,
    parameter int PTS_NORMAL  = 1,
    parameter int COMBO_STEP  = 10,
    parameter int MAX_MULT    = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_clear,
    input  logic [2*NUM_LANES-1:0] i_judge,
    output logic [SCORE_W-1:0]     o_score,
    output logic [CNT_W-1:0]       o_combo,
    output logic [CNT_W-1:0]       o_max_combo,
    output logic [2:0]             o_mult,
    output logic [CNT_W-1:0]       o_perfect_cnt,
    output logic [CNT_W-1:0]       o_normal_cnt,
    output logic [CNT_W-1:0]       o_miss_cnt,
    output logic                   o_evt_valid,
    output logic [2:0]             o_evt_lane,
    output logic [SCORE_W-1:0]     o_evt_pts,
    output logic                   o_overflow
);

    localparam int               SUM_W   = SCORE_W + 4;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [1:0]           r_prev      [NUM_LANES];
    logic [1:0]           r_pend_code [NUM_LANES];
    logic [NUM_LANES-1:0] r_pend_v;
    logic [2:0]           r_ptr;
    logic [SCORE_W-1:0]   r_score;
    logic [CNT_W-1:0]     r_combo;
    logic [CNT_W-1:0]     r_max_combo;
    logic [CNT_W-1:0]     r_perfect_cnt;
    logic [CNT_W-1:0]     r_normal_cnt;
    logic [CNT_W-1:0]     r_miss_cnt;
    logic                 r_evt_valid;
    logic [2:0]           r_evt_lane;
    logic [SCORE_W-1:0]   r_evt_pts;
    logic                 r_overflow;

    logic [NUM_LANES-1:0] w_fire;
    logic [NUM_LANES-1:0] w_gnt_oh;
    logic                 w_grant_v;
    logic [2:0]           w_grant;
    logic [1:0]           w_code;
    logic [2:0]           w_mult;
    logic [SUM_W-1:0]     w_base;
    logic [SUM_W-1:0]     w_pts;
    logic [SUM_W-1:0]     w_sum;
    logic [SCORE_W-1:0]   w_score_nxt;
    logic [CNT_W-1:0]     w_combo_inc;
    logic                 w_drop;

    function automatic logic [2:0] mult_of(input logic [CNT_W-1:0] c);
        logic [CNT_W-1:0] q;
        q = c / CNT_W'(COMBO_STEP);
        if (q >= CNT_W'(MAX_MULT - 1)) return 3'(MAX_MULT);
        return 3'(q) + 3'd1;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_ONE;
    endfunction

    // A lane fires on any change to a non-idle code; holding a code never re-fires.
    always_comb begin
        w_fire = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            w_fire[l] = (i_judge[2*l +: 2] != 2'b00) && (i_judge[2*l +: 2] != r_prev[l]);
        end
    end

    // Slot protocol: a slot is offered while r_pend_v is set and is consumed on the edge its
    // grant is high; a firing event may refill a slot in the same cycle it is consumed.
    always_comb begin
        w_grant_v = 1'b0;
        w_grant   = 3'd0;
        for (int k = 0; k < NUM_LANES; k++) begin
            for (int l = 0; l < NUM_LANES; l++) begin
                if (!w_grant_v && r_pend_v[l] && (((int'(r_ptr) + k) % NUM_LANES) == l)) begin
                    w_grant_v = 1'b1;
                    w_grant   = 3'(l);
                end
            end
        end
        w_gnt_oh = '0;
        w_code   = 2'b00;
        for (int l = 0; l < NUM_LANES; l++) begin
            if (w_grant_v && (w_grant == 3'(l))) begin
                w_gnt_oh[l] = 1'b1;
                w_code      = r_pend_code[l];
            end
        end
    end

    // Points use the multiplier of the combo before this hit; sum is widened then clamped.
    always_comb begin
        w_mult = mult_of(r_combo);
        w_base = '0;
        if (w_code == 2'b11) begin
            w_base = SUM_W'(PTS_PERFECT);
        end else if (w_code == 2'b10) begin
            w_base = SUM_W'(PTS_NORMAL);
        end
        w_pts       = w_base * SUM_W'(w_mult);
        w_sum       = SUM_W'(r_score) + w_pts;
        w_score_nxt = (w_sum[SUM_W-1:SCORE_W] != '0) ? '1 : w_sum[SCORE_W-1:0];
        w_combo_inc = sat_inc(r_combo);
        w_drop      = |(w_fire & r_pend_v & ~w_gnt_oh);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int l = 0; l < NUM_LANES; l++) begin
                r_prev[l]      <= 2'b00;
                r_pend_code[l] <= 2'b00;
            end
            r_pend_v      <= '0;
            r_ptr         <= 3'd0;
            r_score       <= '0;
            r_combo       <= '0;
            r_max_combo   <= '0;
            r_perfect_cnt <= '0;
            r_normal_cnt  <= '0;
            r_miss_cnt    <= '0;
            r_evt_valid   <= 1'b0;
            r_evt_lane    <= 3'd0;
            r_evt_pts     <= '0;
            r_overflow    <= 1'b0;
        end else begin
            for (int l = 0; l < NUM_LANES; l++) begin
                r_prev[l] <= i_judge[2*l +: 2];
            end
            if (i_clear) begin
                r_pend_v      <= '0;
                r_ptr         <= 3'd0;
                r_score       <= '0;
                r_combo       <= '0;
                r_max_combo   <= '0;
                r_perfect_cnt <= '0;
                r_normal_cnt  <= '0;
                r_miss_cnt    <= '0;
                r_evt_valid   <= 1'b0;
                r_evt_lane    <= 3'd0;
                r_evt_pts     <= '0;
                r_overflow    <= 1'b0;
            end else begin
                for (int l = 0; l < NUM_LANES; l++) begin
                    if (w_fire[l] && (!r_pend_v[l] || w_gnt_oh[l])) begin
                        r_pend_v[l]    <= 1'b1;
                        r_pend_code[l] <= i_judge[2*l +: 2];
                    end else if (w_gnt_oh[l]) begin
                        r_pend_v[l] <= 1'b0;
                    end
                end
                if (w_drop) begin
                    r_overflow <= 1'b1;
                end
                r_evt_valid <= w_grant_v;
                if (w_grant_v) begin
                    r_ptr      <= (w_grant == 3'(NUM_LANES - 1)) ? 3'd0 : w_grant + 3'd1;
                    r_evt_lane <= w_grant;
                    r_evt_pts  <= w_pts[SCORE_W-1:0];
                    if (w_code[1]) begin
                        r_score <= w_score_nxt;
                        r_combo <= w_combo_inc;
                        if (w_combo_inc > r_max_combo) begin
                            r_max_combo <= w_combo_inc;
                        end
                        if (w_code[0]) begin
                            r_perfect_cnt <= sat_inc(r_perfect_cnt);
                        end else begin
                            r_normal_cnt <= sat_inc(r_normal_cnt);
                        end
                    end else begin
                        r_combo    <= '0;
                        r_miss_cnt <= sat_inc(r_miss_cnt);
                    end
                end
            end
        end
    end

    assign o_score       = r_score;
    assign o_combo       = r_combo;
    assign o_max_combo   = r_max_combo;
    assign o_mult        = mult_of(r_combo);
    assign o_perfect_cnt = r_perfect_cnt;
    assign o_normal_cnt  = r_normal_cnt;
    assign o_miss_cnt    = r_miss_cnt;
    assign o_evt_valid   = r_evt_valid;
    assign o_evt_lane    = r_evt_lane;
    assign o_evt_pts     = r_evt_pts;
    assign o_overflow    = r_overflow;

endmodule

// File: tb/tb_score_combo_ctrl.sv
// Directed bench for score_combo_ctrl: a per-cycle vector table for basic scoring and
// arbitration, plus hand-written sequences for multiplier, saturation, overflow, clear and reset.
module tb_score_combo_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_clear = 1'b0;
    logic [7:0]  i_judge = 8'h00;
    logic [15:0] o_score;
    logic [9:0]  o_combo;
    logic [9:0]  o_max_combo;
    logic [2:0]  o_mult;
    logic [9:0]  o_perfect_cnt;
    logic [9:0]  o_normal_cnt;
    logic [9:0]  o_miss_cnt;
    logic        o_evt_valid;
    logic [2:0]  o_evt_lane;
    logic [15:0] o_evt_pts;
    logic        o_overflow;

    score_combo_ctrl dut (
        .clk(clk), .rst_n(rst_n), .i_clear(i_clear), .i_judge(i_judge),
        .o_score(o_score), .o_combo(o_combo), .o_max_combo(o_max_combo), .o_mult(o_mult),
        .o_perfect_cnt(o_perfect_cnt), .o_normal_cnt(o_normal_cnt), .o_miss_cnt(o_miss_cnt),
        .o_evt_valid(o_evt_valid), .o_evt_lane(o_evt_lane), .o_evt_pts(o_evt_pts),
        .o_overflow(o_overflow)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    logic [2:0] exp_q[$];

    typedef struct {
        int judge; int clr;
        int ev; int lane; int pts; int score; int combo; int mult; int pc; int nc;
    } vec_t;
    vec_t vt[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic pulse_clear();
        i_judge = 8'h00;
        i_clear = 1'b1;
        @(negedge clk);
        i_clear = 1'b0;
        @(negedge clk);
    endtask

    // n back-to-back events alternating between lanes 0 and 1, then drain.
    task automatic hit_stream(input int n, input logic [1:0] code);
        for (int i = 0; i < n; i++) begin
            i_judge = (i % 2 == 0) ? {6'b0, code} : {4'b0, code, 2'b00};
            @(negedge clk);
        end
        i_judge = 8'h00;
        repeat (3) @(negedge clk);
    endtask

    // Single isolated event; checks the two-cycle latency and the retired record.
    task automatic one_hit(input int lane, input logic [1:0] code, input int exp_pts, input string name);
        i_judge = 8'({6'b0, code}) << (2 * lane);
        @(negedge clk);
        check({name, "_lat"}, o_evt_valid, 0);
        i_judge = 8'h00;
        @(negedge clk);
        check({name, "_valid"}, o_evt_valid, 1);
        check({name, "_lane"}, o_evt_lane, lane);
        check({name, "_pts"}, o_evt_pts, exp_pts);
        @(negedge clk);
        check({name, "_pulse"}, o_evt_valid, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int ev_cnt;
        logic [7:0] burst [8];

        //        judge  clr ev lane pts score combo mult pc nc
        vt[0]  = '{'h03, 0,  0, 0,   0,  0,    0,    1,   0, 0};
        vt[1]  = '{'h03, 0,  1, 0,   2,  2,    1,    1,   1, 0};
        vt[2]  = '{'h03, 0,  0, 0,   0,  2,    1,    1,   1, 0};
        vt[3]  = '{'h03, 0,  0, 0,   0,  2,    1,    1,   1, 0};
        vt[4]  = '{'h00, 1,  0, 0,   0,  0,    0,    1,   0, 0};
        vt[5]  = '{'hAA, 0,  0, 0,   0,  0,    0,    1,   0, 0};
        vt[6]  = '{'hAA, 0,  1, 0,   1,  1,    1,    1,   0, 1};
        vt[7]  = '{'hAA, 0,  1, 1,   1,  2,    2,    1,   0, 2};
        vt[8]  = '{'hAA, 0,  1, 2,   1,  3,    3,    1,   0, 3};
        vt[9]  = '{'hAA, 0,  1, 3,   1,  4,    4,    1,   0, 4};
        vt[10] = '{'h00, 0,  0, 0,   0,  4,    4,    1,   0, 4};

        repeat (3) @(negedge clk);
        check("rst_score", o_score, 0);
        check("rst_combo", o_combo, 0);
        check("rst_max", o_max_combo, 0);
        check("rst_mult", o_mult, 1);
        check("rst_pcnt", o_perfect_cnt, 0);
        check("rst_ncnt", o_normal_cnt, 0);
        check("rst_mcnt", o_miss_cnt, 0);
        check("rst_evt", o_evt_valid, 0);
        check("rst_lane", o_evt_lane, 0);
        check("rst_pts", o_evt_pts, 0);
        check("rst_ovf", o_overflow, 0);
        rst_n = 1'b1;

        // Held Perfect fires once; clear; four-lane burst retires in lane order.
        for (int i = 0; i < 11; i++) begin
            i_judge = 8'(vt[i].judge);
            i_clear = vt[i].clr[0];
            @(negedge clk);
            check($sformatf("v%0d_evt", i), o_evt_valid, vt[i].ev);
            check($sformatf("v%0d_score", i), o_score, vt[i].score);
            check($sformatf("v%0d_combo", i), o_combo, vt[i].combo);
            check($sformatf("v%0d_mult", i), o_mult, vt[i].mult);
            check($sformatf("v%0d_pcnt", i), o_perfect_cnt, vt[i].pc);
            check($sformatf("v%0d_ncnt", i), o_normal_cnt, vt[i].nc);
            if (vt[i].ev != 0) begin
                check($sformatf("v%0d_lane", i), o_evt_lane, vt[i].lane);
                check($sformatf("v%0d_pts", i), o_evt_pts, vt[i].pts);
            end
        end
        i_clear = 1'b0;

        // Multiplier step at 10 hits, then a Miss.
        pulse_clear();
        hit_stream(10, 2'b10);
        check("m_score10", o_score, 10);
        check("m_combo10", o_combo, 10);
        check("m_mult10", o_mult, 2);
        one_hit(0, 2'b11, 4, "m_perf");
        check("m_score14", o_score, 14);
        check("m_combo11", o_combo, 11);
        check("m_pcnt", o_perfect_cnt, 1);
        one_hit(2, 2'b01, 0, "m_miss");
        check("m_miss_score", o_score, 14);
        check("m_miss_combo", o_combo, 0);
        check("m_miss_mult", o_mult, 1);
        check("m_max", o_max_combo, 11);
        check("m_mcnt", o_miss_cnt, 1);

        // Ramp to the multiplier ceiling, then to 65534, then saturate.
        pulse_clear();
        hit_stream(10, 2'b10);
        hit_stream(1, 2'b11);
        hit_stream(9, 2'b10);
        hit_stream(10, 2'b10);
        check("s_score62", o_score, 62);
        check("s_mult4", o_mult, 4);
        hit_stream(16368, 2'b10);
        check("s_score_near", o_score, 65534);
        check("s_combo_sat", o_combo, 1023);
        check("s_max_sat", o_max_combo, 1023);
        check("s_ncnt_sat", o_normal_cnt, 1023);
        check("s_pcnt", o_perfect_cnt, 1);
        one_hit(0, 2'b11, 8, "s_perf");
        check("s_score_sat", o_score, 65535);
        check("s_pcnt2", o_perfect_cnt, 2);
        one_hit(1, 2'b10, 4, "s_norm");
        check("s_score_hold", o_score, 65535);

        // Lane 1 served last in a burst while it toggles twice: both toggles dropped.
        pulse_clear();
        one_hit(1, 2'b10, 1, "o_prep");
        burst = '{8'hAA, 8'hAE, 8'hAA, 8'hAA, 8'hAA, 8'h00, 8'h00, 8'h00};
        exp_q = {3'd2, 3'd3, 3'd0, 3'd1};
        ev_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            i_judge = burst[i];
            @(negedge clk);
            if (o_evt_valid) begin
                ev_cnt++;
                if (exp_q.size() == 0) begin
                    check("o_extra_evt_lane", o_evt_lane, 7);
                end else begin
                    check("o_order", o_evt_lane, exp_q.pop_front());
                end
            end
        end
        check("o_evt_count", ev_cnt, 4);
        check("o_q_drained", exp_q.size(), 0);
        check("o_overflow", o_overflow, 1);
        check("o_score", o_score, 5);
        check("o_combo", o_combo, 5);

        // Clear coinciding with a grant and with a new event.
        pulse_clear();
        check("c_ovf", o_overflow, 0);
        check("c_max", o_max_combo, 0);
        check("c_mcnt", o_miss_cnt, 0);
        i_judge = 8'hAA;
        @(negedge clk);
        check("c_load_evt", o_evt_valid, 0);
        @(negedge clk);
        check("c_grant_evt", o_evt_valid, 1);
        check("c_grant_score", o_score, 1);
        i_judge = 8'hAB;
        i_clear = 1'b1;
        @(negedge clk);
        i_clear = 1'b0;
        i_judge = 8'h00;
        check("c_clr_evt", o_evt_valid, 0);
        check("c_clr_score", o_score, 0);
        check("c_clr_combo", o_combo, 0);
        check("c_clr_ncnt", o_normal_cnt, 0);
        ev_cnt = 0;
        repeat (4) begin
            @(negedge clk);
            if (o_evt_valid) ev_cnt++;
        end
        check("c_no_late_evt", ev_cnt, 0);
        check("c_after_score", o_score, 0);

        // Asynchronous reset in the middle of a burst.
        i_judge = 8'hAA;
        @(negedge clk);
        @(negedge clk);
        check("r_pre_score", o_score, 1);
        #2;
        rst_n = 1'b0;
        i_judge = 8'h00;
        #1;
        check("r_async_score", o_score, 0);
        check("r_async_combo", o_combo, 0);
        check("r_async_evt", o_evt_valid, 0);
        check("r_async_ncnt", o_normal_cnt, 0);
        check("r_async_mult", o_mult, 1);
        @(negedge clk);
        rst_n = 1'b1;
        ev_cnt = 0;
        repeat (4) begin
            @(negedge clk);
            if (o_evt_valid) ev_cnt++;
        end
        check("r_lost_evt", ev_cnt, 0);
        check("r_lost_score", o_score, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
